score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Sequential score source for the pong display path. Counts goals for both
//  players, commits score changes only at frame boundaries (no mid-frame digit
//  tearing), runs serve-delay and game-over control, and drives the 4-bit
//  digit values consumed by the per-player score renderers.
// PARAMETERS
//  WIN_SCORE     9    score that ends the game; legal 1..9 (single digit)
//  SERVE_FRAMES  60   frames ball is held after reset/goal/new game; 1..255
//  CNT_W         8    width of serve frame counter; must hold SERVE_FRAMES
// PORTS
//  clk         in   1   pixel/system clock, single clock domain
//  rst_n       in   1   asynchronous active-low reset
//  frame_tick  in   1   1-cycle pulse at start of vertical blanking
//  goal_p1     in   1   1-cycle pulse: player 1 scored
//  goal_p2     in   1   1-cycle pulse: player 2 scored
//  new_game    in   1   1-cycle pulse: restart match
//  point1      out  4   player 1 score, 0..WIN_SCORE
//  point2      out  4   player 2 score, 0..WIN_SCORE
//  serve_hold  out  1   1 = ball must stay frozen at serve position
//  game_over   out  1   1 = match finished
//  winner      out  2   00 none, 01 p1, 10 p2, 11 both reached WIN same frame
// BEHAVIOUR
//  - Reset (async, rst_n=0): point1=point2=0, winner=00, game_over=0,
//    serve_hold=1, state=SERVE, serve_cnt=SERVE_FRAMES, all pending flags 0.
//  - All outputs registered; change only on the clk edge after a frame_tick.
//  - Pending flags pend1/pend2/pend_ng set by goal_p1/goal_p2/new_game pulses.
//    Pulse coincident with frame_tick counts in that frame: effective =
//    pend | pulse. All pending flags clear on every frame_tick.
//  - States: SERVE, PLAY, OVER. serve_hold=1 in SERVE and OVER, 0 in PLAY.
//    game_over=1 only in OVER.
//  - new_game has highest priority, any state: on frame_tick with effective
//    new_game -> points 0, winner 00, serve_cnt=SERVE_FRAMES, state SERVE.
//    Goals effective in that same frame are discarded.
//  - SERVE: goals discarded. Each frame_tick decrements serve_cnt; the
//    frame_tick on which serve_cnt==1 -> state PLAY (hold = SERVE_FRAMES frames).
//  - PLAY, frame_tick with effective goal(s): each scoring player +1; both
//    goals same frame -> both +1. Then if any point==WIN_SCORE -> OVER,
//    winner set from which reached WIN_SCORE; else -> SERVE, reload serve_cnt.
//    frame_tick with no goal: stay PLAY, no change.
//  - OVER: goals discarded; points and winner frozen until new_game.
//  - Scores never exceed WIN_SCORE (saturate; no wrap to 0).
//  - Reset mid-frame or mid-serve: immediate return to reset values.
//  - Goal pulse with no later frame_tick stays pending indefinitely.
// STRUCTURE
//  - Shared package pong_pkg: state enum {SERVE,PLAY,OVER}, DIGIT_W=4,
//    WINNER_* codes, MAX_DIGIT=9.
//  - One natural sub-module: event_latch (pulse -> sticky flag, clear on
//    frame_tick, pass-through of coincident pulse); instantiated 3x.
//  - Top holds FSM, score registers, serve counter.
// TESTING
//  1 Reset, SERVE_FRAMES=3: serve_hold=1 for 3 frame_ticks, 0 after 3rd;
//    points stay 0/0.
//  2 PLAY, goal_p1 mid-frame -> point1 unchanged until next frame_tick, then
//    1; serve_hold=1 for next 3 frames; goal_p2 during SERVE ignored.
//  3 goal_p1 and goal_p2 same frame in PLAY at 3/4 -> 4/5 next frame.
//  4 WIN_SCORE=9, point1=8, goal_p1 -> point1=9, game_over=1, winner=01;
//    further goals ignored, point1 stays 9.
//  5 Both at 8, goals same frame -> 9/9, winner=11; new_game -> 0/0,
//    winner=00, SERVE after next frame_tick.
//  6 goal_p1 pulse on same cycle as frame_tick -> counted that frame;
//    rst_n low mid-SERVE -> all outputs to reset values immediately.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong scoring path: FSM states, digit
// width, winner codes and a saturating digit increment.
package pong_pkg;

  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 9;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_BOTH = 2'b11;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_e;

  // Adds one when inc is set, but never steps past lim.
  function automatic logic [DIGIT_W-1:0] sat_inc(input logic [DIGIT_W-1:0] v,
                                                 input logic               inc,
                                                 input logic [DIGIT_W-1:0] lim);
    logic [DIGIT_W-1:0] r;
    r = v;
    if (inc && (v < lim)) r = v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/event_latch.sv
// Turns a one-cycle pulse into a sticky flag that lives until the next
// frame_tick; a pulse landing on the tick itself is passed straight through.
module event_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  input  logic frame_tick,
  output logic eff
);

  logic pend_q;
  logic pend_d;

  always_comb begin
    pend_d = frame_tick ? 1'b0 : (pend_q | pulse);
    eff    = pend_q | pulse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end

endmodule

// File: rtl/score_keeper.sv
// Pong score source: latches goal/new-game pulses and commits score, serve
// delay and game-over changes only on the edge after a frame_tick.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               goal_p1,
  input  logic               goal_p2,
  input  logic               new_game,
  output logic [DIGIT_W-1:0] point1,
  output logic [DIGIT_W-1:0] point2,
  output logic               serve_hold,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [DIGIT_W-1:0] WIN_D    = DIGIT_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  logic g1_eff, g2_eff, ng_eff;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         win_q, win_d;
  logic               hold_q, hold_d;
  logic               over_q, over_d;
  logic [DIGIT_W-1:0] n1, n2;

  event_latch u_latch_p1 (.clk(clk), .rst_n(rst_n), .pulse(goal_p1),  .frame_tick(frame_tick), .eff(g1_eff));
  event_latch u_latch_p2 (.clk(clk), .rst_n(rst_n), .pulse(goal_p2),  .frame_tick(frame_tick), .eff(g2_eff));
  event_latch u_latch_ng (.clk(clk), .rst_n(rst_n), .pulse(new_game), .frame_tick(frame_tick), .eff(ng_eff));

  // State register, including the score datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SERVE;
      cnt_q   <= SERVE_LD;
      p1_q    <= '0;
      p2_q    <= '0;
      win_q   <= WINNER_NONE;
      hold_q  <= 1'b1;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      over_q  <= over_d;
    end
  end

  // Next state: nothing moves except on a frame_tick; new_game beats goals.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    n1      = sat_inc(p1_q, g1_eff, WIN_D);
    n2      = sat_inc(p2_q, g2_eff, WIN_D);
    if (frame_tick) begin
      if (ng_eff) begin
        state_d = SERVE;
        cnt_d   = SERVE_LD;
        p1_d    = '0;
        p2_d    = '0;
        win_d   = WINNER_NONE;
      end else begin
        case (state_q)
          SERVE: begin
            if (cnt_q <= CNT_ONE) begin
              state_d = PLAY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          PLAY: begin
            if (g1_eff || g2_eff) begin
              p1_d = n1;
              p2_d = n2;
              if ((n1 == WIN_D) || (n2 == WIN_D)) begin
                state_d = OVER;
                win_d   = {(n2 == WIN_D), (n1 == WIN_D)};
              end else begin
                state_d = SERVE;
                cnt_d   = SERVE_LD;
              end
            end
          end
          OVER:    state_d = OVER;
          default: state_d = SERVE;
        endcase
      end
    end
  end

  // Output decode from the next state so the flags register alongside it.
  always_comb begin
    hold_d = (state_d != PLAY);
    over_d = (state_d == OVER);
  end

  assign point1     = p1_q;
  assign point2     = p2_q;
  assign winner     = win_q;
  assign serve_hold = hold_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper (WIN_SCORE=9, SERVE_FRAMES=3) with an
// expected-output queue checked after every stimulus step that asks for it.
`timescale 1ns/1ps
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       goal_p1 = 1'b0;
  logic       goal_p2 = 1'b0;
  logic       new_game = 1'b0;
  logic [3:0] point1, point2;
  logic       serve_hold, game_over;
  logic [1:0] winner;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  score_keeper #(.WIN_SCORE(9), .SERVE_FRAMES(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .goal_p1(goal_p1), .goal_p2(goal_p2), .new_game(new_game),
    .point1(point1), .point2(point2), .serve_hold(serve_hold),
    .game_over(game_over), .winner(winner)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] pack(input int p1, input int p2, input int hold,
                                       input int over, input int win);
    return {4'(p1), 4'(p2), 1'(hold), 1'(over), 2'(win)};
  endfunction

  // Scoreboard: pop the oldest expectation and compare the whole output word.
  task automatic check_out(input string tag);
    logic [11:0] exp_v, obs_v;
    obs_v = {point1, point2, serve_hold, game_over, winner};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs_v === exp_v) else begin
        failures++;
        $error("FAIL %s: observed p1=%0d p2=%0d hold=%0b over=%0b win=%b, expected p1=%0d p2=%0d hold=%0b over=%0b win=%b",
               tag, obs_v[11:8], obs_v[7:4], obs_v[3], obs_v[2], obs_v[1:0],
               exp_v[11:8], exp_v[7:4], exp_v[3], exp_v[2], exp_v[1:0]);
      end
    end
  endtask

  // Driver: one clock of stimulus; optionally expect a result after the edge.
  task automatic step(input logic g1, input logic g2, input logic ng, input logic ft,
                      input bit chk, input int e1, input int e2, input int eh,
                      input int eo, input int ew, input string tag);
    @(negedge clk);
    goal_p1 = g1; goal_p2 = g2; new_game = ng; frame_tick = ft;
    if (chk) exp_q.push_back(pack(e1, e2, eh, eo, ew));
    @(posedge clk);
    #1;
    goal_p1 = 1'b0; goal_p2 = 1'b0; new_game = 1'b0; frame_tick = 1'b0;
    if (chk) check_out(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
  endtask

  // From PLAY: score a point mid-frame, commit it on the tick, ride out the serve.
  task automatic play_point(input logic g1, input logic g2, input int e1, input int e2,
                            input string tag);
    idle($urandom_range(0, 3));
    step(g1, g2, 0, 0, 0, 0, 0, 0, 0, 0, "");
    step(0, 0, 0, 1, 1, e1, e2, 1, 0, 0, tag);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "");
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "");
    step(0, 0, 0, 1, 1, e1, e2, 0, 0, 0, {tag, "_served"});
  endtask

  task automatic serve_out(input int e1, input int e2, input string tag);
    step(0, 0, 0, 1, 1, e1, e2, 1, 0, 0, {tag, "_t1"});
    step(0, 0, 0, 1, 1, e1, e2, 1, 0, 0, {tag, "_t2"});
    step(0, 0, 0, 1, 1, e1, e2, 0, 0, 0, {tag, "_t3"});
  endtask

  initial begin
    // 1: reset values, then serve hold for exactly three frames
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(pack(0, 0, 1, 0, 0));
    check_out("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    serve_out(0, 0, "serve");

    // 2: mid-frame goal held until the tick; goal during serve ignored
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "goal_mid_frame");
    idle(3);
    step(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, "goal_commit");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "");
    step(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, "serve_goal_ignored_t1");
    step(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, "serve_goal_ignored_t2");
    step(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, "serve_goal_ignored_t3");

    // 3: build to 3/4, then both score in one frame
    play_point(1, 1, 2, 1, "p_2_1");
    play_point(0, 1, 2, 2, "p_2_2");
    play_point(0, 1, 2, 3, "p_2_3");
    play_point(1, 1, 3, 4, "p_3_4");
    play_point(1, 1, 4, 5, "both_goal");

    // 4: p1 reaches 9 and wins; later goals ignored
    play_point(1, 0, 5, 5, "p_5_5");
    play_point(1, 0, 6, 5, "p_6_5");
    play_point(1, 0, 7, 5, "p_7_5");
    play_point(1, 0, 8, 5, "p_8_5");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    step(0, 0, 0, 1, 1, 9, 5, 1, 1, 1, "p1_wins");
    step(1, 1, 0, 1, 1, 9, 5, 1, 1, 1, "over_goals_ignored");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    step(0, 0, 1, 0, 1, 9, 5, 1, 1, 1, "ng_waits_for_tick");
    step(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, "ng_clears_goal");

    // 5: both reach 9 in one frame, then new game
    serve_out(0, 0, "ng_serve");
    for (int k = 1; k <= 8; k++) play_point(1, 1, k, k, $sformatf("tie_%0d", k));
    step(1, 1, 0, 1, 1, 9, 9, 1, 1, 3, "both_win");
    step(0, 0, 1, 0, 1, 9, 9, 1, 1, 3, "ng_pending");
    step(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, "ng_restart");

    // 6: idle tick in play, long-pending goal, coincident pulses, async reset
    serve_out(0, 0, "ng2_serve");
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, "play_idle_tick");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    idle(20);
    step(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, "long_pending_goal");
    step(0, 0, 0, 1, 1, 1, 0, 1, 0, 0, "pre_reset_serve");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(pack(0, 0, 1, 0, 0));
    check_out("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    serve_out(0, 0, "post_reset");
    step(1, 0, 0, 1, 1, 1, 0, 1, 0, 0, "coincident_goal");
    serve_out(1, 0, "coin_serve");
    step(0, 1, 1, 1, 1, 0, 0, 1, 0, 0, "coincident_ng_beats_goal");

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover: %0d expectations never checked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
